// File: rtl/ripple_cnt_pkg.sv
// Shared types and helpers for the ripple counter monitor.
package ripple_cnt_pkg;

    localparam int CNT_W = 4;

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_t;

    // Forward distance from old to new on the 4-bit wheel.
    function automatic logic [CNT_W-1:0] mod_delta(input logic [CNT_W-1:0] new_v,
                                                   input logic [CNT_W-1:0] old_v);
        return new_v - old_v;
    endfunction

endpackage

// File: rtl/cnt_sync_filter.sv
// Brings the asynchronous ripple count into clk and accepts only values that
// have been stable for STABLE_N consecutive synchronized samples.
module cnt_sync_filter
    import ripple_cnt_pkg::*;
#(
    parameter int STABLE_N = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] cnt_in,
    output logic [CNT_W-1:0] cnt_q,
    output logic             cnt_update,
    output logic             wrap,
    output logic [CNT_W-1:0] delta,
    output logic             acc,
    output logic [CNT_W-1:0] acc_delta
);

    localparam int               RUN_W   = $clog2(STABLE_N + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STABLE_N);
    localparam logic [CNT_W:0]   CNT_MAX = (CNT_W + 1)'((1 << CNT_W) - 1);

    logic [CNT_W-1:0] s1;
    logic [CNT_W-1:0] s2;
    logic [CNT_W-1:0] run_val;
    logic [RUN_W-1:0] run_len;
    logic             acc_wrap;

    // acc is the acceptance decision for the coming edge; the top uses it so
    // a delta landing on the window-closing edge is counted in that window.
    assign acc       = (run_len == RUN_MAX) && (run_val != cnt_q);
    assign acc_delta = mod_delta(run_val, cnt_q);
    assign acc_wrap  = ({1'b0, cnt_q} + {1'b0, acc_delta}) > CNT_MAX;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1         <= '0;
            s2         <= '0;
            run_val    <= '0;
            run_len    <= '0;
            cnt_q      <= '0;
            cnt_update <= 1'b0;
            wrap       <= 1'b0;
            delta      <= '0;
        end else begin
            s1 <= cnt_in;
            s2 <= s1;
            if (s2 == run_val) begin
                if (run_len != RUN_MAX) run_len <= run_len + 1'b1;
            end else begin
                run_val <= s2;
                run_len <= RUN_W'(1);
            end
            cnt_update <= acc;
            wrap       <= acc && acc_wrap;
            delta      <= acc ? acc_delta : '0;
            if (acc) cnt_q <= run_val;
        end
    end

endmodule

// File: rtl/ripple_count_monitor.sv
// Filtered ripple count plus gated rate measurement with a one-deep
// valid/ready result buffer.
module ripple_count_monitor
    import ripple_cnt_pkg::*;
#(
    parameter int GATE_CYCLES = 1000,
    parameter int MEAS_W      = 16,
    parameter int STABLE_N    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CNT_W-1:0]  cnt_in,
    output logic [CNT_W-1:0]  cnt_q,
    output logic              cnt_update,
    output logic              wrap,
    output logic [CNT_W-1:0]  cnt_delta,
    output logic              meas_valid,
    input  logic              meas_ready,
    output logic [MEAS_W-1:0] meas_count,
    output logic              meas_sat,
    output logic              meas_lost,
    input  logic              lost_clr,
    output out_state_t        dbg_state
);

    // Handshake: a result transfers on any rising edge where meas_valid and
    // meas_ready are both high; meas_count/meas_sat hold until that edge.

    localparam int                GATE_W    = $clog2(GATE_CYCLES);
    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);

    logic              acc;
    logic [CNT_W-1:0]  acc_delta;
    logic [GATE_W-1:0] gate_cnt;
    logic              gate_close;
    logic [MEAS_W-1:0] tally;
    logic              sat_flag;
    logic [MEAS_W:0]   sum;
    logic [MEAS_W-1:0] tally_next;
    logic              sat_next;
    out_state_t        state;

    cnt_sync_filter #(
        .STABLE_N (STABLE_N)
    ) u_filt (
        .clk        (clk),
        .rst        (rst),
        .cnt_in     (cnt_in),
        .cnt_q      (cnt_q),
        .cnt_update (cnt_update),
        .wrap       (wrap),
        .delta      (cnt_delta),
        .acc        (acc),
        .acc_delta  (acc_delta)
    );

    assign gate_close = (gate_cnt == GATE_LAST);
    assign dbg_state  = state;

    // The extra sum bit flags overflow; the tally then pins at all-ones.
    always_comb begin
        sum        = {1'b0, tally} + (MEAS_W + 1)'(acc ? acc_delta : '0);
        tally_next = sum[MEAS_W] ? '1 : sum[MEAS_W-1:0];
        sat_next   = sat_flag | sum[MEAS_W];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gate_cnt   <= '0;
            tally      <= '0;
            sat_flag   <= 1'b0;
            state      <= OUT_EMPTY;
            meas_valid <= 1'b0;
            meas_count <= '0;
            meas_sat   <= 1'b0;
            meas_lost  <= 1'b0;
        end else begin
            gate_cnt <= gate_close ? '0 : gate_cnt + 1'b1;
            if (gate_close) begin
                tally    <= '0;
                sat_flag <= 1'b0;
            end else begin
                tally    <= tally_next;
                sat_flag <= sat_next;
            end
            // A drop below overrides this clear on the same edge.
            if (lost_clr) meas_lost <= 1'b0;
            case (state)
                OUT_EMPTY: begin
                    if (gate_close) begin
                        meas_count <= tally_next;
                        meas_sat   <= sat_next;
                        meas_valid <= 1'b1;
                        state      <= OUT_FULL;
                    end
                end
                OUT_FULL: begin
                    if (meas_ready) begin
                        if (gate_close) begin
                            meas_count <= tally_next;
                            meas_sat   <= sat_next;
                        end else begin
                            meas_valid <= 1'b0;
                            state      <= OUT_EMPTY;
                        end
                    end else if (gate_close) begin
                        meas_lost <= 1'b1;
                    end
                end
                default: state <= OUT_EMPTY;
            endcase
        end
    end

endmodule
